// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates instruction and data line requests onto one memory port
// One transaction in flight; ties alternate using the side granted last.
module mem_port_arbiter #(
   parameter int WORD_SIZE   = 16,
   parameter int BLOCK_SIZE  = 64,
   parameter int MEM_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_req,
   input  logic [WORD_SIZE-1:0]  i_addr,
   output logic                  i_ready,
   output logic [BLOCK_SIZE-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [WORD_SIZE-1:0]  d_addr,
   input  logic [BLOCK_SIZE-1:0] d_wdata,
   output logic                  d_ready,
   output logic [BLOCK_SIZE-1:0] d_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [WORD_SIZE-1:0]  mem_addr,
   output logic [BLOCK_SIZE-1:0] mem_wdata,
   input  logic [BLOCK_SIZE-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   localparam logic [3:0]           CNT_TERM  = 4'(MEM_LATENCY - 1);
   localparam logic [WORD_SIZE-1:0] LINE_MASK = ~(WORD_SIZE'(3));

   state_t                r_state;
   state_t                w_next_state;
   logic [3:0]            r_cnt;
   logic                  r_last_grant_d;
   logic                  r_owner_d;
   logic                  r_we;
   logic [WORD_SIZE-1:0]  r_addr;
   logic [BLOCK_SIZE-1:0] r_wdata;
   logic [BLOCK_SIZE-1:0] r_i_rdata;
   logic [BLOCK_SIZE-1:0] r_d_rdata;
   logic                  w_grant_valid;
   logic                  w_grant_d;
   logic                  w_resp_read;

   always_comb begin
      w_next_state  = r_state;
      w_grant_valid = 1'b0;
      w_grant_d     = 1'b0;
      case (r_state)
         IDLE: begin
            w_grant_valid = i_req | d_req;
            // On a tie the side not served last wins
            w_grant_d     = (i_req && d_req) ? ~r_last_grant_d : d_req;
            if (w_grant_valid)
               w_next_state = ACCESS;
         end
         ACCESS: w_next_state = (MEM_LATENCY > 1) ? WAIT : RESP;
         WAIT: begin
            if (r_cnt == CNT_TERM)
               w_next_state = RESP;
         end
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state        <= IDLE;
         r_cnt          <= 4'd0;
         r_last_grant_d <= 1'b0;
         r_owner_d      <= 1'b0;
         r_we           <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_i_rdata      <= '0;
         r_d_rdata      <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               r_cnt <= 4'd0;
               if (w_grant_valid) begin
                  r_owner_d <= w_grant_d;
                  r_we      <= w_grant_d & d_we;
                  r_addr    <= (w_grant_d ? d_addr : i_addr) & LINE_MASK;
                  r_wdata   <= (w_grant_d && d_we) ? d_wdata : '0;
               end
            end
            ACCESS: r_cnt <= 4'd1;
            WAIT:   r_cnt <= r_cnt + 4'd1;
            RESP: begin
               r_cnt          <= 4'd0;
               r_last_grant_d <= r_owner_d;
               if (!r_we) begin
                  if (r_owner_d)
                     r_d_rdata <= mem_rdata;
                  else
                     r_i_rdata <= mem_rdata;
               end
            end
            default: r_cnt <= 4'd0;
         endcase
      end
   end

   assign w_resp_read = (r_state == RESP) && !r_we;

   assign busy      = (r_state != IDLE);
   assign mem_read  = (r_state == ACCESS) && !r_we;
   assign mem_write = (r_state == ACCESS) && r_we;
   assign mem_addr  = (r_state == IDLE) ? '0 : r_addr;
   assign mem_wdata = (r_state == IDLE) ? '0 : r_wdata;
   assign i_ready   = (r_state == RESP) && !r_owner_d;
   assign d_ready   = (r_state == RESP) && r_owner_d;
   // Read data is valid from memory during RESP, so forward it in the ready cycle
   assign i_rdata   = (w_resp_read && !r_owner_d) ? mem_rdata : r_i_rdata;
   assign d_rdata   = (w_resp_read && r_owner_d) ? mem_rdata : r_d_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, address/word width.
REQ-002 SHALL have parameter BLOCK_SIZE, default 64, line width (4 words).
REQ-003 SHALL have parameter MEM_LATENCY, default 4, cycles from memory strobe to valid read data; legal range 1..15.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 i_req  in  1  instruction-side line-fill request; held high until i_ready.
REQ-007 i_addr  in  WORD_SIZE  instruction-side word address.
REQ-008 i_ready  out  1  one-cycle pulse: instruction transaction complete, i_rdata valid.
REQ-009 i_rdata  out  BLOCK_SIZE  instruction-side returned line.
REQ-010 d_req  in  1  data-side request; held high until d_ready.
REQ-011 d_we  in  1  data-side request is write (1) or read (0).
REQ-012 d_addr  in  WORD_SIZE  data-side word address.
REQ-013 d_wdata  in  BLOCK_SIZE  data-side write line.
REQ-014 d_ready  out  1  one-cycle pulse: data transaction complete, d_rdata valid for reads.
REQ-015 d_rdata  out  BLOCK_SIZE  data-side returned line.
REQ-016 mem_read  out  1  memory read strobe.
REQ-017 mem_write  out  1  memory write strobe.
REQ-018 mem_addr  out  WORD_SIZE  memory line address.
REQ-019 mem_wdata  out  BLOCK_SIZE  memory write line.
REQ-020 mem_rdata  in  BLOCK_SIZE  memory read line.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states IDLE, ACCESS, WAIT, RESP; one transaction in flight at a time.
REQ-023 IDLE: no request -> stay; one request -> latch it, go ACCESS; both -> grant side not granted last (last_grant register), go ACCESS.
REQ-024 Latch at grant: owner, address with bits [1:0] forced to 00, d_we, d_wdata; later changes on request inputs ignored until RESP.
REQ-025 ACCESS (exactly 1 cycle): mem_read=1 for reads or mem_write=1 for data writes, never both; mem_addr=latched address; go WAIT if MEM_LATENCY>1, else RESP.
REQ-026 WAIT: 4-bit counter counts MEM_LATENCY-1 cycles, strobes low, mem_addr/mem_wdata held stable; counter reaching terminal -> RESP.
REQ-027 RESP (exactly 1 cycle): read -> capture mem_rdata into owner's rdata register; owner's ready pulses high; update last_grant=owner; go IDLE.
REQ-028 Latency: request sampled in IDLE at edge t -> strobe in cycle t+1 -> ready in cycle t+1+MEM_LATENCY.
REQ-029 Writes: d_ready pulses at same latency; d_rdata unchanged.
REQ-030 i_rdata/d_rdata hold last captured value until next read completion for that side.
REQ-031 Requester deasserts req in cycle after its ready; req still high in IDLE after ready is treated as new request.
REQ-032 Requests with same line address from both sides: served sequentially, no merging.
REQ-033 mem_addr, mem_wdata = 0 in IDLE; i_ready and d_ready never high in same cycle.

Reset
REQ-034 reset_n=0 at rising edge: state=IDLE, counter=0, last_grant=I (first tie goes to D), all outputs 0, i_rdata=d_rdata=0.
REQ-035 Reset mid-transaction aborts it: no ready pulse, no strobe in following cycle.

Verification
REQ-036 i_req, i_addr=16'h0025, MEM_LATENCY=4 -> mem_read one cycle with mem_addr=16'h0024; i_ready 5 cycles after sampling; i_rdata=mem_rdata captured.
REQ-037 i_req and d_req (read 16'h0040) together after reset -> D served first, then I; last_grant alternates over 4 consecutive ties.
REQ-038 d_req, d_we=1, d_addr=16'h0081, d_wdata=64'h0004_0003_0002_0001 -> mem_write one cycle, mem_addr=16'h0080, mem_wdata stable through WAIT; d_ready pulse; d_rdata unchanged.
REQ-039 MEM_LATENCY=1 -> ACCESS straight to RESP; ready 2 cycles after sampling.
REQ-040 reset_n=0 during WAIT -> next cycle busy=0, no ready pulse; subsequent i_req completes normally.
REQ-041 Back-to-back: d_req held high one cycle past d_ready -> second transaction starts; busy=0 for exactly that one IDLE cycle.
